// File: rtl/param_waveform_generator.sv
// Phase-accumulator waveform source: ramp, triangle, PWM, staircase, LFSR noise and DC
// shapes derived from the top bits of a free-running phase, with hold, wrap and mode restart.
module param_waveform_generator #(
   parameter int          WIDTH     = 8,
   parameter int          PHASE_W   = 16,
   parameter int          STEP_BITS = 3,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [2:0]         func_sel,
   input  logic [PHASE_W-1:0] freq_step,
   input  logic [WIDTH-1:0]   duty,
   output logic [WIDTH-1:0]   wave,
   output logic               wrap
);

   typedef enum logic [2:0] {
      FN_RAMP_UP   = 3'b000,
      FN_RAMP_DOWN = 3'b001,
      FN_TRIANGLE  = 3'b010,
      FN_PWM       = 3'b011,
      FN_STAIR     = 3'b100,
      FN_NOISE     = 3'b101,
      FN_DC        = 3'b110,
      FN_ZERO      = 3'b111
   } func_e;

   localparam logic [WIDTH-1:0] MAX        = '1;
   localparam logic [WIDTH-1:0] STAIR_MASK = MAX << (WIDTH - STEP_BITS);

   logic [PHASE_W-1:0] phase_q, phase_d;
   logic [WIDTH-1:0]   wave_q, wave_d;
   logic               wrap_q, wrap_d;
   logic [15:0]        lfsr_q, lfsr_d;
   logic [2:0]         sel_q, sel_d;

   logic [PHASE_W:0]   sum;
   logic               restart;
   logic [WIDTH:0]     phase_hi;
   logic [WIDTH-1:0]   ptop;
   logic [WIDTH-1:0]   tri_t;
   logic               msb;
   logic [WIDTH-1:0]   sample;

   assign sum     = {1'b0, phase_q} + {1'b0, freq_step};
   assign restart = (func_sel != sel_q);

   // Only the top WIDTH+1 phase bits shape the sample; a restart evaluates the new shape at phase 0.
   assign phase_hi = restart ? '0 : phase_q[PHASE_W-1 -: WIDTH+1];
   assign msb      = phase_hi[WIDTH];
   assign ptop     = phase_hi[WIDTH:1];
   assign tri_t    = phase_hi[WIDTH-1:0];

   // NOTE: every output of a combinational block gets a default before the case, so no latch is inferred.
   always_comb begin
      sample = '0;
      case (func_e'(func_sel))
         FN_RAMP_UP:   sample = ptop;
         FN_RAMP_DOWN: sample = MAX - ptop;
         FN_TRIANGLE:  sample = msb ? ~tri_t : tri_t;
         FN_PWM:       sample = (ptop < duty) ? MAX : '0;
         FN_STAIR:     sample = ptop & STAIR_MASK;
         FN_NOISE:     sample = lfsr_q[15 -: WIDTH];
         FN_DC:        sample = duty;
         FN_ZERO:      sample = '0;
         default:      sample = '0;
      endcase
   end

   always_comb begin
      phase_d = phase_q;
      wave_d  = wave_q;
      wrap_d  = 1'b0;
      lfsr_d  = lfsr_q;
      sel_d   = sel_q;
      if (en) begin
         lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
         sel_d  = func_sel;
         wave_d = sample;
         if (restart) begin
            phase_d = '0;
         end else begin
            phase_d = sum[PHASE_W-1:0];
            wrap_d  = sum[PHASE_W];
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         phase_q <= '0;
         wave_q  <= '0;
         wrap_q  <= 1'b0;
         lfsr_q  <= LFSR_SEED;
         sel_q   <= FN_RAMP_UP;
      end else begin
         phase_q <= phase_d;
         wave_q  <= wave_d;
         wrap_q  <= wrap_d;
         lfsr_q  <= lfsr_d;
         sel_q   <= sel_d;
      end
   end

   assign wave = wave_q;
   assign wrap = wrap_q;

endmodule

// File: tb/tb_param_waveform_generator.sv
// Directed bench for param_waveform_generator at WIDTH=8, PHASE_W=16, STEP_BITS=3.
module tb_param_waveform_generator;

   logic        clk;
   logic        rst;
   logic        en;
   logic [2:0]  func_sel;
   logic [15:0] freq_step;
   logic [7:0]  duty;
   logic [7:0]  wave;
   logic        wrap;

   int tests_run    = 0;
   int tests_failed = 0;

   param_waveform_generator #(
      .WIDTH(8), .PHASE_W(16), .STEP_BITS(3), .LFSR_SEED(16'hACE1)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .func_sel(func_sel),
      .freq_step(freq_step), .duty(duty), .wave(wave), .wrap(wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset;
      rst = 1'b0;
      tick();
      rst = 1'b1;
   endtask

   task automatic test_reset;
      en = 1'b1; func_sel = 3'b000; freq_step = 16'h0100; duty = 8'd0;
      apply_reset();
      for (int i = 0; i < 5; i++) tick();
      #2 rst = 1'b0;
      #1;
      tests_run++;
      if (wave !== 8'd0 || wrap !== 1'b0) begin
         tests_failed++;
         $display("FAIL async_reset: wave=%h wrap=%b, required wave=00 wrap=0", wave, wrap);
      end
      en = 1'b0;
      #2 rst = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         tests_run++;
         if (wave !== 8'd0 || wrap !== 1'b0) begin
            tests_failed++;
            $display("FAIL hold_after_reset cyc %0d: wave=%h wrap=%b, required 00/0", i, wave, wrap);
         end
      end
      en = 1'b1;
      for (int n = 1; n <= 3; n++) begin
         tick();
         tests_run++;
         if (wave !== 8'(n - 1)) begin
            tests_failed++;
            $display("FAIL phase_frozen edge %0d: wave=%h, required %h", n, wave, 8'(n - 1));
         end
      end
   endtask

   task automatic test_ramp(input logic [15:0] step, input int period);
      logic [7:0] exp_w;
      logic       exp_wr;
      en = 1'b1; func_sel = 3'b000; freq_step = step;
      apply_reset();
      for (int n = 1; n <= 2 * period + 1; n++) begin
         tick();
         exp_w  = 8'(((n - 1) * 256 / period) % 256);
         exp_wr = (n % period == 0);
         tests_run++;
         if (wave !== exp_w || wrap !== exp_wr) begin
            tests_failed++;
            $display("FAIL ramp step=%h edge %0d: wave=%h wrap=%b, required %h/%b",
                     step, n, wave, wrap, exp_w, exp_wr);
         end
      end
   endtask

   task automatic test_triangle;
      int         k;
      logic [7:0] exp_w;
      logic       exp_wr;
      en = 1'b1; func_sel = 3'b010; freq_step = 16'h0100;
      apply_reset();
      tick();
      tests_run++;
      if (wave !== 8'd0 || wrap !== 1'b0) begin
         tests_failed++;
         $display("FAIL triangle_restart: wave=%h wrap=%b, required 00/0", wave, wrap);
      end
      for (int n = 2; n <= 2 + 512; n++) begin
         tick();
         k      = (n - 2) % 256;
         exp_w  = (k < 128) ? 8'(2 * k) : 8'(255 - 2 * (k - 128));
         exp_wr = ((n - 1) % 256 == 0);
         tests_run++;
         if (wave !== exp_w || wrap !== exp_wr) begin
            tests_failed++;
            $display("FAIL triangle edge %0d: wave=%h wrap=%b, required %h/%b", n, wave, wrap, exp_w, exp_wr);
         end
      end
   endtask

   task automatic test_pwm_dc;
      logic [7:0] exp_w;
      int         zeros;
      en = 1'b1; func_sel = 3'b011; freq_step = 16'h0100; duty = 8'd64;
      apply_reset();
      tick();
      tests_run++;
      if (wave !== 8'hFF) begin
         tests_failed++;
         $display("FAIL pwm_restart: wave=%h, required ff", wave);
      end
      for (int n = 2; n <= 2 + 256; n++) begin
         tick();
         exp_w = (((n - 2) % 256) < 64) ? 8'hFF : 8'h00;
         tests_run++;
         if (wave !== exp_w) begin
            tests_failed++;
            $display("FAIL pwm64 edge %0d: wave=%h, required %h", n, wave, exp_w);
         end
      end
      duty = 8'd0;
      for (int n = 0; n < 300; n++) begin
         tick();
         tests_run++;
         if (wave !== 8'h00) begin
            tests_failed++;
            $display("FAIL pwm_duty0 cyc %0d: wave=%h, required 00", n, wave);
         end
      end
      duty  = 8'hFF;
      zeros = 0;
      for (int n = 0; n < 256; n++) begin
         tick();
         if (wave == 8'h00) zeros++;
      end
      tests_run++;
      if (zeros != 1) begin
         tests_failed++;
         $display("FAIL pwm_duty_max: zero samples=%0d per period, required 1", zeros);
      end
      func_sel = 3'b110; duty = 8'h5A;
      for (int n = 0; n < 20; n++) begin
         tick();
         tests_run++;
         if (wave !== 8'h5A) begin
            tests_failed++;
            $display("FAIL dc cyc %0d: wave=%h, required 5a", n, wave);
         end
      end
   endtask

   task automatic test_staircase;
      logic [7:0] exp_w;
      en = 1'b1; func_sel = 3'b100; freq_step = 16'h0100;
      apply_reset();
      tick();
      for (int n = 2; n <= 2 + 256; n++) begin
         tick();
         exp_w = 8'(((n - 2) % 256) / 32 * 32);
         tests_run++;
         if (wave !== exp_w) begin
            tests_failed++;
            $display("FAIL staircase edge %0d: wave=%h, required %h", n, wave, exp_w);
         end
      end
   endtask

   task automatic test_noise;
      logic [7:0] exp_seq [5];
      int         zero_run;
      int         max_run;
      exp_seq = '{8'hAC, 8'h59, 8'hB3, 8'h67, 8'hCE};
      en = 1'b1; func_sel = 3'b101; freq_step = 16'h0100;
      apply_reset();
      for (int n = 0; n < 5; n++) begin
         tick();
         tests_run++;
         if (wave !== exp_seq[n]) begin
            tests_failed++;
            $display("FAIL noise edge %0d: wave=%h, required %h", n + 1, wave, exp_seq[n]);
         end
      end
      zero_run = 0;
      max_run  = 0;
      for (int n = 6; n <= 65536; n++) begin
         tick();
         zero_run = (wave == 8'h00) ? zero_run + 1 : 0;
         if (zero_run > max_run) max_run = zero_run;
      end
      tests_run++;
      if (max_run > 8) begin
         tests_failed++;
         $display("FAIL noise_stuck: %0d consecutive zero samples, required at most 8", max_run);
      end
      tests_run++;
      if (wave !== 8'hAC) begin
         tests_failed++;
         $display("FAIL noise_period: wave after 65535 shifts=%h, required ac", wave);
      end
   endtask

   task automatic test_mode_switch;
      en = 1'b1; func_sel = 3'b000; freq_step = 16'h0100;
      apply_reset();
      for (int n = 1; n <= 129; n++) tick();
      tests_run++;
      if (wave !== 8'h80) begin
         tests_failed++;
         $display("FAIL switch_setup: wave=%h, required 80", wave);
      end
      func_sel = 3'b001;
      tick();
      tests_run++;
      if (wave !== 8'hFF || wrap !== 1'b0) begin
         tests_failed++;
         $display("FAIL switch_restart: wave=%h wrap=%b, required ff/0", wave, wrap);
      end
      tick();
      tick();
      tests_run++;
      if (wave !== 8'hFE) begin
         tests_failed++;
         $display("FAIL switch_after: wave=%h, required fe", wave);
      end
      #2 rst = 1'b0;
      #1;
      tests_run++;
      if (wave !== 8'h00 || wrap !== 1'b0) begin
         tests_failed++;
         $display("FAIL midcycle_reset: wave=%h wrap=%b, required 00/0", wave, wrap);
      end
      tick();
      rst = 1'b1;
   endtask

   task automatic test_hold_defer;
      en = 1'b1; func_sel = 3'b000; freq_step = 16'h0100;
      apply_reset();
      for (int n = 1; n <= 256; n++) tick();
      tests_run++;
      if (wave !== 8'hFF || wrap !== 1'b1) begin
         tests_failed++;
         $display("FAIL wrap_edge: wave=%h wrap=%b, required ff/1", wave, wrap);
      end
      en = 1'b0; func_sel = 3'b111;
      for (int n = 0; n < 5; n++) begin
         tick();
         tests_run++;
         if (wave !== 8'hFF || wrap !== 1'b0) begin
            tests_failed++;
            $display("FAIL hold_defer cyc %0d: wave=%h wrap=%b, required ff/0", n, wave, wrap);
         end
      end
      en = 1'b1;
      tick();
      tests_run++;
      if (wave !== 8'h00 || wrap !== 1'b0) begin
         tests_failed++;
         $display("FAIL deferred_restart: wave=%h wrap=%b, required 00/0", wave, wrap);
      end
   endtask

   task automatic test_zero_step;
      en = 1'b1; func_sel = 3'b000; freq_step = 16'h0000;
      apply_reset();
      for (int n = 0; n < 300; n++) begin
         tick();
         tests_run++;
         if (wave !== 8'h00 || wrap !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_step cyc %0d: wave=%h wrap=%b, required 00/0", n, wave, wrap);
         end
      end
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; func_sel = 3'b000; freq_step = '0; duty = '0;
      #1;
      test_reset();
      test_ramp(16'h0100, 256);
      test_ramp(16'h0080, 512);
      test_triangle();
      test_pwm_dc();
      test_staircase();
      test_noise();
      test_mode_switch();
      test_hold_defer();
      test_zero_step();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
